// File: rtl/mqnic_app_cfg_ram_arb.sv
// mqnic_app_cfg_ram_arb
//   Shares read port B of the application queue-config RAM between REQ_COUNT
//   datapath requesters and returns each read result to its requester as a
//   one-hot tag. Host config writes are registered onto RAM port A. A read of
//   the entry being written in the same cycle is held off.
//
//   Optional feature macro: CFG_RAM_ARB_FIXED_PRIO_EN
//     defined   : fixed priority, lowest eligible index wins (no pointer)
//     undefined : round-robin starting after the last granted requester
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_addr       per-requester read request handshake
//   rsp_valid/rsp_data                 one-hot response tag and shared data
//   cfg_wr_en/cfg_wr_addr/cfg_wr_data  host config write
//   ram_wen/ram_waddr/ram_wdata        RAM port A (registered write)
//   ram_ren/ram_raddr/ram_rdata        RAM port B (combinational read drive)
module mqnic_app_cfg_ram_arb #(
  parameter int unsigned REQ_COUNT         = 2,
  parameter int unsigned CONFIG_RAM_AWIDTH = 4,
  parameter int unsigned CONFIG_RAM_DWIDTH = 512,
  parameter int unsigned RAM_RD_DLY        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [REQ_COUNT-1:0]                   req_valid,
  output logic [REQ_COUNT-1:0]                   req_ready,
  input  logic [REQ_COUNT*CONFIG_RAM_AWIDTH-1:0] req_addr,
  output logic [REQ_COUNT-1:0]                   rsp_valid,
  output logic [CONFIG_RAM_DWIDTH-1:0]           rsp_data,
  input  logic                                   cfg_wr_en,
  input  logic [CONFIG_RAM_AWIDTH-1:0]           cfg_wr_addr,
  input  logic [CONFIG_RAM_DWIDTH-1:0]           cfg_wr_data,
  output logic                                   ram_wen,
  output logic [CONFIG_RAM_AWIDTH-1:0]           ram_waddr,
  output logic [CONFIG_RAM_DWIDTH-1:0]           ram_wdata,
  output logic                                   ram_ren,
  output logic [CONFIG_RAM_AWIDTH-1:0]           ram_raddr,
  input  logic [CONFIG_RAM_DWIDTH-1:0]           ram_rdata
);

  localparam int unsigned AW    = CONFIG_RAM_AWIDTH;
  localparam int unsigned DW    = CONFIG_RAM_DWIDTH;
  localparam int unsigned PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

  logic          wen_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic [REQ_COUNT-1:0] eligible_c;
  logic [REQ_COUNT-1:0] grant_c;
  logic                 found_c;

  logic [REQ_COUNT-1:0] tag_q [RAM_RD_DLY];

  // Host write path: one register stage, never stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= cfg_wr_en;
      waddr_q <= cfg_wr_addr;
      wdata_q <= cfg_wr_data;
    end
  end

  assign ram_wen   = wen_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wdata_q;

  // Eligibility: mask reads that hit the entry written this cycle; the
  // rst_n term keeps the combinational grant low while in reset
  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      eligible_c[i] = rst_n && req_valid[i] &&
                      !(wen_q && (req_addr[i*AW +: AW] == waddr_q));
    end
  end

`ifdef CFG_RAM_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest eligible index wins
  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (!found_c && eligible_c[i]) begin
        found_c    = 1'b1;
        grant_c[i] = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] gnt_idx_c;
  int               idx_c;

  // Round-robin: search starts one past the last grant and wraps
  always_comb begin
    grant_c   = '0;
    gnt_idx_c = '0;
    found_c   = 1'b0;
    idx_c     = 0;
    for (int off = 1; off <= REQ_COUNT; off++) begin
      idx_c = (int'(ptr_q) + off) % REQ_COUNT;
      if (!found_c && eligible_c[idx_c]) begin
        found_c          = 1'b1;
        grant_c[idx_c]   = 1'b1;
        gnt_idx_c        = PTR_W'(idx_c);
      end
    end
  end

  // Last-grant pointer moves only on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_W'(REQ_COUNT - 1);
    end else if (found_c) begin
      ptr_q <= gnt_idx_c;
    end
  end
`endif

  assign req_ready = grant_c;
  assign ram_ren   = found_c;

  // Read address of the granted requester, zero when idle
  always_comb begin
    ram_raddr = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant_c[i]) begin
        ram_raddr = req_addr[i*AW +: AW];
      end
    end
  end

  // Tag pipeline aligned with RAM read latency; reset drops in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RAM_RD_DLY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= grant_c;
      for (int k = 1; k < RAM_RD_DLY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign rsp_valid = tag_q[RAM_RD_DLY-1];
  assign rsp_data  = ram_rdata;

endmodule
